fb_writer: RTL and testbench
============================

FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter FB_W, default 320, framebuffer width in pixels.
REQ-002 Parameter FB_H, default 240, framebuffer height in pixels.
REQ-003 Parameter CBITS, default `COLOR_BITS, color word width.
REQ-004 Parameter ABITS, default 17, memory address width; FB_W*FB_H SHALL be <= 2^ABITS.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 vld_in  in  1  pixel stream valid from rasterizer output.
REQ-008 rdy_in  out  1  pixel stream ready back to rasterizer.
REQ-009 pixel_x  in  10  unsigned pixel column.
REQ-010 pixel_y  in  10  unsigned pixel row.
REQ-011 color_in  in  CBITS  pixel color.
REQ-012 clear_req  in  1  one-cycle request to fill framebuffer.
REQ-013 clear_color  in  CBITS  fill value, sampled with clear_req.
REQ-014 mem_we  out  1  memory write strobe.
REQ-015 mem_addr  out  ABITS  memory word address.
REQ-016 mem_wdata  out  CBITS  memory write data.
REQ-017 mem_rdy  in  1  memory accepts a write when mem_we && mem_rdy.
REQ-018 busy  out  1  high while in CLEAR or a write is pending.
REQ-019 clear_done  out  1  one-cycle pulse after last clear write accepted.
REQ-020 drop_cnt  out  16  saturating count of out-of-bounds pixels discarded.

Function
REQ-021 Handshake: a pixel transfers on a cycle with vld_in && rdy_in; no other cycle consumes a pixel.
REQ-022 States SHALL be RUN and CLEAR; reset state RUN.
REQ-023 RUN: one output register (mem_we/mem_addr/mem_wdata); rdy_in = !mem_we || mem_rdy (register empty or draining this cycle).
REQ-024 Accepted in-bounds pixel (x < FB_W, y < FB_H) loads register next cycle: mem_addr = y*FB_W + x, mem_wdata = color_in, mem_we = 1; latency 1 cycle from accept to mem_we.
REQ-025 Address product SHALL be computed at full 20-bit precision then truncated to ABITS.
REQ-026 Accepted out-of-bounds pixel SHALL be consumed, not written; drop_cnt += 1, saturating at 0xFFFF.
REQ-027 mem_we, mem_addr, mem_wdata SHALL hold stable while mem_we && !mem_rdy.
REQ-028 Register clears (mem_we=0) after accept with no new pixel; accept and new load in same cycle keeps mem_we=1 (back-to-back, one pixel/cycle).
REQ-029 clear_req in RUN: latch clear_color; rdy_in = 0 from next cycle; enter CLEAR once pending pixel write accepted (or immediately if none).
REQ-030 CLEAR: addresses 0..FB_W*FB_H-1 written in ascending order with latched color; address advances only on mem_rdy.
REQ-031 Last clear address accepted -> clear_done = 1 for exactly one cycle, return to RUN, rdy_in reasserts next cycle.
REQ-032 clear_req during CLEAR SHALL be ignored; latched color unchanged.
REQ-033 rdy_in = 0 throughout CLEAR; vld_in ignored.
REQ-034 clear_req and pixel accept in same cycle: pixel written first, then clear.
REQ-035 busy = (state==CLEAR) || mem_we.

Reset
REQ-036 rst SHALL force, next edge: state RUN, mem_we 0, mem_addr 0, mem_wdata 0, clear_done 0, drop_cnt 0, clear counter 0.
REQ-037 rdy_in = 1 on first cycle after rst deasserts.
REQ-038 rst mid-CLEAR or with write pending SHALL abort it; no further mem_we until new input.

Verification
REQ-039 mem_rdy=1, pixels (0,0,A),(319,239,B),(5,2,C) back-to-back -> mem writes addr 0/A, 76799/B, 645/C on consecutive cycles.
REQ-040 mem_rdy=0 for 3 cycles with pixel (1,0,D) pending -> mem_we/addr 1/data D held, rdy_in=0, one write on mem_rdy rise.
REQ-041 Pixels (320,0),(0,240),(1023,1023) -> no mem_we, drop_cnt=3; drop_cnt preloaded 0xFFFF stays 0xFFFF.
REQ-042 clear_req, clear_color=0x1234, mem_rdy=1 -> 76800 writes addr 0..76799 data 0x1234, single clear_done pulse, rdy_in=0 throughout.
REQ-043 Clear with mem_rdy toggling 50% -> no skipped/duplicated address; second clear_req mid-clear ignored.
REQ-044 rst asserted at clear address 1000 -> next cycle mem_we=0, state RUN, rdy_in=1 after release, no clear_done.

Source files
------------

// File: rtl/fb_writer.sv
// Framebuffer writer: turns a rasterizer pixel stream into memory writes
// through a single output register, and can fill the whole buffer with one color.
`ifndef COLOR_BITS
`define COLOR_BITS 16
`endif

module fb_writer #(
  parameter int FB_W  = 320,
  parameter int FB_H  = 240,
  parameter int CBITS = `COLOR_BITS,
  parameter int ABITS = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  output logic             rdy_in,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic [CBITS-1:0] color_in,
  input  logic             clear_req,
  input  logic [CBITS-1:0] clear_color,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_addr,
  output logic [CBITS-1:0] mem_wdata,
  input  logic             mem_rdy,
  output logic             busy,
  output logic             clear_done,
  output logic [15:0]      drop_cnt
);

  typedef enum logic {RUN, CLEAR} state_t;

  localparam logic [10:0]      W_LIM     = 11'(FB_W);
  localparam logic [10:0]      H_LIM     = 11'(FB_H);
  localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(FB_W * FB_H - 1);

  state_t           state, state_nxt;
  logic             clr_pend;
  logic [CBITS-1:0] clr_color;
  logic             drain_ok, accept, in_bounds, clr_start, clr_last;
  logic [19:0]      addr_full;

  // NOTE: every always_comb output gets a value before any branch, so no path
  // can leave a signal unassigned and infer a latch.
  always_comb begin
    drain_ok  = !mem_we || mem_rdy;
    rdy_in    = (state == RUN) && !clr_pend && drain_ok;
    accept    = vld_in && rdy_in;
    in_bounds = ({1'b0, pixel_x} < W_LIM) && ({1'b0, pixel_y} < H_LIM);
    addr_full = {10'd0, pixel_y} * 20'(FB_W) + {10'd0, pixel_x};
    // A pixel accepted alongside clear_req is written first; the fill starts
    // once the output register is free.
    clr_start = (state == RUN) && (clr_pend || clear_req) && !accept && drain_ok;
    clr_last  = (state == CLEAR) && mem_rdy && (mem_addr == LAST_ADDR);
    busy      = (state == CLEAR) || mem_we;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (clr_start) state_nxt = CLEAR;
      CLEAR:   if (clr_last)  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      clear_done <= 1'b0;
      drop_cnt   <= '0;
      clr_pend   <= 1'b0;
      clr_color  <= '0;
    end else begin
      clear_done <= clr_last;
      if (state == RUN) begin
        if (mem_we && mem_rdy) mem_we <= 1'b0;
        if (accept && in_bounds) begin
          mem_we    <= 1'b1;
          mem_addr  <= ABITS'(addr_full);
          mem_wdata <= color_in;
        end
        if (accept && !in_bounds && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        if (clear_req && !clr_pend) clr_color <= clear_color;
        if (clr_start) begin
          // The fill reuses the output register; mem_addr is the fill counter.
          mem_we    <= 1'b1;
          mem_addr  <= '0;
          mem_wdata <= clr_pend ? clr_color : clear_color;
          clr_pend  <= 1'b0;
        end else if (clear_req) begin
          clr_pend <= 1'b1;
        end
      end else if (mem_rdy) begin
        if (clr_last) mem_we   <= 1'b0;
        else          mem_addr <= mem_addr + ABITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: a full-size instance for pixel addressing and
// reset abort, a 16x8 instance for complete fill sequences.
module tb_fb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_in, clear_req, mem_rdy;
  logic [9:0]  pixel_x, pixel_y;
  logic [15:0] color_in, clear_color;

  logic        rdy, we, busy, done;
  logic [16:0] addr;
  logic [15:0] wdata, drops;
  logic        rdy_s, we_s, busy_s, done_s;
  logic [6:0]  addr_s;
  logic [15:0] wdata_s, drops_s;

  int checks = 0, failures = 0;
  int wr_big = 0, mon_s = 0, exp_addr_s = 0, mon_err = 0, done_cnt_s = 0;
  logic [15:0] exp_col_s = '0;
  int n0, rdy_viol, stray;

  always #5 clk = ~clk;

  fb_writer #(.FB_W(320), .FB_H(240), .CBITS(16), .ABITS(17)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_in(rdy), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .color_in(color_in), .clear_req(clear_req),
    .clear_color(clear_color), .mem_we(we), .mem_addr(addr), .mem_wdata(wdata),
    .mem_rdy(mem_rdy), .busy(busy), .clear_done(done), .drop_cnt(drops));

  fb_writer #(.FB_W(16), .FB_H(8), .CBITS(16), .ABITS(7)) dut_s (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_in(rdy_s), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .color_in(color_in), .clear_req(clear_req),
    .clear_color(clear_color), .mem_we(we_s), .mem_addr(addr_s), .mem_wdata(wdata_s),
    .mem_rdy(mem_rdy), .busy(busy_s), .clear_done(done_s), .drop_cnt(drops_s));

  // Transfers are observed mid-cycle, after inputs have settled.
  always @(negedge clk) begin
    if (we && mem_rdy) wr_big++;
    if (mon_s != 0 && we_s && mem_rdy) begin
      if (addr_s !== 7'(exp_addr_s) || wdata_s !== exp_col_s) mon_err++;
      exp_addr_s++;
    end
    if (mon_s != 0 && done_s) done_cnt_s++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic [15:0] c);
    vld_in   = 1'b1;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    color_in = c;
  endtask

  initial begin
    rst = 1'b1; vld_in = 1'b0; clear_req = 1'b0; mem_rdy = 1'b1;
    pixel_x = '0; pixel_y = '0; color_in = '0; clear_color = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_done", done, 0);
    check("rst_drops", drops, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", rdy, 1);

    // Back-to-back in-bounds pixels, including the far corner.
    pix(0, 0, 16'h00A0);     tick();
    check("b2b0_we", we, 1); check("b2b0_addr", addr, 0); check("b2b0_data", wdata, 16'h00A0);
    pix(319, 239, 16'h00B0); tick();
    check("b2b1_we", we, 1); check("b2b1_addr", addr, 76799); check("b2b1_data", wdata, 16'h00B0);
    pix(5, 2, 16'h00C0);     tick();
    check("b2b2_addr", addr, 645); check("b2b2_data", wdata, 16'h00C0);
    check("b2b2_small_addr", addr_s, 37);
    vld_in = 1'b0; tick();
    check("b2b_idle_we", we, 0);

    // Output register holds while memory stalls.
    mem_rdy = 1'b0;
    pix(1, 0, 16'h00D0); tick();
    n0 = wr_big;
    pix(2, 0, 16'h00E0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_rdy", rdy, 0);
      check("stall_we", we, 1);
      check("stall_addr", addr, 1);
      check("stall_data", wdata, 16'h00D0);
      tick();
    end
    mem_rdy = 1'b1; #1;
    check("stall_release_rdy", rdy, 1);
    tick();
    check("stall_next_addr", addr, 2); check("stall_next_data", wdata, 16'h00E0);
    vld_in = 1'b0; tick();
    check("stall_writes", wr_big - n0, 2);

    // Out-of-bounds pixels are consumed and counted.
    pix(320, 0, 16'h1111);    tick(); check("oob_x_we", we, 0);
    pix(0, 240, 16'h2222);    tick(); check("oob_y_we", we, 0);
    pix(1023, 1023, 16'h3333); tick(); check("oob_xy_we", we, 0);
    vld_in = 1'b0;
    check("oob_drops", drops, 3);

    // Complete fill of the small buffer with memory always ready.
    exp_addr_s = 0; exp_col_s = 16'h1234; mon_err = 0; done_cnt_s = 0; mon_s = 1;
    clear_color = 16'h1234; clear_req = 1'b1; tick();
    clear_req = 1'b0;
    check("clr_start_we", we_s, 1); check("clr_start_addr", addr_s, 0);
    check("clr_start_data", wdata_s, 16'h1234); check("clr_start_busy", busy_s, 1);
    rdy_viol = 0;
    for (int i = 0; i < 300; i++) begin
      if (done_s) break;
      if (rdy_s) rdy_viol++;
      tick();
    end
    check("clr_done_seen", done_s, 1);
    check("clr_count", exp_addr_s, 128);
    check("clr_order", mon_err, 0);
    check("clr_rdy_low", rdy_viol, 0);
    check("clr_rdy_back", rdy_s, 1);
    tick();
    check("clr_done_pulse", done_s, 0);
    check("clr_done_count", done_cnt_s, 1);

    // Fill with a stuttering memory and a second request mid-fill.
    exp_addr_s = 0; exp_col_s = 16'h00AB; mon_err = 0; done_cnt_s = 0;
    clear_color = 16'h00AB; clear_req = 1'b1; tick();
    for (int i = 0; i < 600; i++) begin
      mem_rdy     = (i % 2) == 1;
      clear_req   = (i == 20);
      clear_color = (i == 20) ? 16'hFFFF : 16'h00AB;
      tick();
      if (done_s) break;
    end
    clear_req = 1'b0; mem_rdy = 1'b1;
    check("tog_done_seen", done_s, 1);
    check("tog_count", exp_addr_s, 128);
    check("tog_order", mon_err, 0);
    tick(); tick();
    check("tog_done_count", done_cnt_s, 1);
    check("tog_no_restart", we_s, 0);
    mon_s = 0;

    // Pixel and clear request together: pixel first, then the fill.
    pix(3, 1, 16'h0777); clear_color = 16'h0055; clear_req = 1'b1; tick();
    vld_in = 1'b0; clear_req = 1'b0;
    check("both_pix_addr", addr_s, 19); check("both_pix_data", wdata_s, 16'h0777);
    check("both_rdy", rdy_s, 0);
    tick();
    check("both_clr_addr", addr_s, 0); check("both_clr_data", wdata_s, 16'h0055);
    check("both_clr_busy", busy_s, 1);
    for (int i = 0; i < 300; i++) begin
      if (done_s) break;
      tick();
    end
    check("both_clr_done", done_s, 1);

    // Reset aborts a fill on the full-size buffer.
    rst = 1'b1; tick(); rst = 1'b0;
    clear_color = 16'h0F0F; clear_req = 1'b1; tick(); clear_req = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (addr == 17'd1000) break;
      tick();
    end
    check("abort_reached", addr, 1000);
    rst = 1'b1; tick();
    check("abort_we", we, 0); check("abort_busy", busy, 0);
    check("abort_done", done, 0); check("abort_addr", addr, 0);
    rst = 1'b0; #1;
    check("abort_rdy", rdy, 1);
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (we || done) stray++;
    end
    check("abort_quiet", stray, 0);

    // Drop counter saturates.
    pix(1023, 1023, 16'h0001);
    repeat (65534) tick();
    check("sat_fffe", drops, 16'hFFFE);
    tick();
    check("sat_ffff", drops, 16'hFFFF);
    repeat (2) tick();
    check("sat_hold", drops, 16'hFFFF);
    check("sat_no_we", we, 0);
    vld_in = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
